// File: rtl/braille_spi_frame_rx.sv
// SPI mode-0 command receiver for the braille actuator driver: deframes 16-bit
// commands into a shadow dot pattern and pulse width. Readback via miso is built
// only when BRAILLE_SPI_READBACK_EN is defined; otherwise miso is tied low.
module braille_spi_frame_rx #(
  parameter int          FRAME_BITS  = 16,
  parameter logic [11:0] PULSE_RESET = 12'd100
) (
  input  logic        clock,
  input  logic        reset,
  input  logic        sclk,
  input  logic        mosi,
  input  logic        ss_n,
  input  logic        latch_data_n,
  output logic        miso,
  output logic [9:0]  pattern,
  output logic [11:0] pulse_width,
  output logic        pattern_update,
  output logic        frame_strobe,
  output logic        frame_error
);

  localparam int CNT_W = $clog2(FRAME_BITS + 1);

  typedef enum logic [1:0] {IDLE, SHIFT, DONE} state_e;

  state_e state_q, state_d;

  logic [2:0] sclkSync_q, ssSync_q, latchSync_q;
  logic [1:0] mosiSync_q;

  logic [CNT_W-1:0]      bitCnt_q;
  logic [FRAME_BITS-1:0] rxShift_q;
  logic [9:0]            shadow_q, pattern_q;
  logic [11:0]           pulseWidth_q;
  logic                  patternUpdate_q, frameStrobe_q, frameError_q;
  logic                  decodePend_q;

  logic sclkRise, ssFall, ssRise, latchFall, lastBit;
  logic clearCnt, shiftRx, abortFrame, enterDone, decodeEn;

  // Bit [1] of each synchroniser is the synced level, bit [2] its delayed copy.
  always_ff @(posedge clock or posedge reset) begin
    if (reset) begin
      sclkSync_q  <= 3'b000;
      ssSync_q    <= 3'b111;
      latchSync_q <= 3'b111;
      mosiSync_q  <= 2'b00;
    end else begin
      sclkSync_q  <= {sclkSync_q[1:0], sclk};
      ssSync_q    <= {ssSync_q[1:0], ss_n};
      latchSync_q <= {latchSync_q[1:0], latch_data_n};
      mosiSync_q  <= {mosiSync_q[0], mosi};
    end
  end

  assign sclkRise  = sclkSync_q[1] & ~sclkSync_q[2];
  assign ssFall    = ~ssSync_q[1] & ssSync_q[2];
  assign ssRise    = ssSync_q[1] & ~ssSync_q[2];
  assign latchFall = ~latchSync_q[1] & latchSync_q[2];
  assign lastBit   = (bitCnt_q == CNT_W'(FRAME_BITS - 1));

  always_ff @(posedge clock or posedge reset) begin
    if (reset) state_q <= IDLE;
    else       state_q <= state_d;
  end

  always_comb begin
    state_d = state_q;
    case (state_q)
      IDLE:    if (ssFall) state_d = SHIFT;
      SHIFT: begin
        if (ssRise)                  state_d = IDLE;
        else if (sclkRise && lastBit) state_d = DONE;
      end
      DONE:    if (ssRise) state_d = IDLE;
      default: state_d = IDLE;
    endcase
  end

  always_comb begin
    clearCnt   = 1'b0;
    shiftRx    = 1'b0;
    abortFrame = 1'b0;
    enterDone  = 1'b0;
    decodeEn   = 1'b0;
    case (state_q)
      IDLE:  clearCnt = ssFall;
      SHIFT: begin
        abortFrame = ssRise;
        shiftRx    = sclkRise & ~ssRise;
        enterDone  = sclkRise & ~ssRise & lastBit;
      end
      DONE:  decodeEn = decodePend_q;
      default: ;
    endcase
  end

  // An abort and a CLEAR_ERROR decode live in different states, so never collide.
  always_ff @(posedge clock or posedge reset) begin
    if (reset) begin
      bitCnt_q        <= '0;
      rxShift_q       <= '0;
      shadow_q        <= '0;
      pattern_q       <= '0;
      pulseWidth_q    <= PULSE_RESET;
      patternUpdate_q <= 1'b0;
      frameStrobe_q   <= 1'b0;
      frameError_q    <= 1'b0;
      decodePend_q    <= 1'b0;
    end else begin
      decodePend_q    <= enterDone;
      frameStrobe_q   <= decodeEn;
      patternUpdate_q <= latchFall;
      if (clearCnt)     bitCnt_q <= '0;
      else if (shiftRx) bitCnt_q <= bitCnt_q + CNT_W'(1);
      if (shiftRx) rxShift_q <= {rxShift_q[FRAME_BITS-2:0], mosiSync_q[1]};
      if (latchFall) pattern_q <= shadow_q;
      if (decodeEn) begin
        case (rxShift_q[15:12])
          4'h1: shadow_q <= rxShift_q[9:0];
          4'h2: pulseWidth_q <= (rxShift_q[11:0] == 12'd0) ? 12'd1 : rxShift_q[11:0];
          default: ;
        endcase
      end
      if (abortFrame)                                frameError_q <= 1'b1;
      else if (decodeEn && rxShift_q[15:12] == 4'h3) frameError_q <= 1'b0;
    end
  end

`ifdef BRAILLE_SPI_READBACK_EN
  logic [FRAME_BITS-1:0] txShift_q;
  logic                  sclkFall;

  assign sclkFall = ~sclkSync_q[1] & sclkSync_q[2];

  always_ff @(posedge clock or posedge reset) begin
    if (reset)
      txShift_q <= '0;
    else if (state_q == IDLE && ssFall)
      txShift_q <= {4'b1010, 1'b0, frameError_q, pattern_q};
    else if (state_q == SHIFT && sclkFall && !ssRise)
      txShift_q <= {txShift_q[FRAME_BITS-2:0], 1'b0};
  end

  always_comb begin
    miso = 1'b0;
    if (state_q == SHIFT) miso = txShift_q[FRAME_BITS-1];
  end
`else
  assign miso = 1'b0;
`endif

  assign pattern        = pattern_q;
  assign pulse_width    = pulseWidth_q;
  assign pattern_update = patternUpdate_q;
  assign frame_strobe   = frameStrobe_q;
  assign frame_error    = frameError_q;

endmodule

// File: tb/tb_braille_spi_frame_rx.sv
// Self-checking bench for braille_spi_frame_rx: directed scenarios followed by
// random frames, all checked against a frame-level reference model.
module tb_braille_spi_frame_rx;

  logic        clock = 1'b0;
  logic        reset, sclk, mosi, ss_n, latch_data_n;
  logic        miso;
  logic [9:0]  pattern;
  logic [11:0] pulse_width;
  logic        pattern_update, frame_strobe, frame_error;

  int compareCount = 0;
  int failCount    = 0;
  int strobeCount  = 0;
  int updateCount  = 0;

  logic [9:0]  mShadow, mPattern;
  logic [11:0] mPulse;
  logic        mErr;
  logic [15:0] capWord;

  braille_spi_frame_rx #(.FRAME_BITS(16), .PULSE_RESET(12'd100)) dut (
    .clock(clock), .reset(reset), .sclk(sclk), .mosi(mosi), .ss_n(ss_n),
    .latch_data_n(latch_data_n), .miso(miso), .pattern(pattern),
    .pulse_width(pulse_width), .pattern_update(pattern_update),
    .frame_strobe(frame_strobe), .frame_error(frame_error)
  );

  always #5 clock = ~clock;

  always @(negedge clock) begin
    if (frame_strobe)   strobeCount++;
    if (pattern_update) updateCount++;
  end

  task automatic waitClocks(input int n);
    repeat (n) @(negedge clock);
  endtask

  task automatic checkOutput(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    compareCount++;
    assert (obs === exp) else begin
      failCount++;
      $error("[TB] FAIL %s: observed=%0h expected=%0h", tag, obs, exp);
    end
  endtask

  task automatic modelReset();
    mShadow  = 10'd0;
    mPattern = 10'd0;
    mPulse   = 12'd100;
    mErr     = 1'b0;
  endtask

  task automatic modelDecode(input logic [15:0] word);
    case (word[15:12])
      4'h1: mShadow = word[9:0];
      4'h2: mPulse  = (word[11:0] == 12'd0) ? 12'd1 : word[11:0];
      4'h3: mErr    = 1'b0;
      default: ;
    endcase
  endtask

  function automatic logic [15:0] expectedReadback();
`ifdef BRAILLE_SPI_READBACK_EN
    return {4'hA, 1'b0, mErr, mPattern};
`else
    return 16'h0000;
`endif
  endfunction

  task automatic checkState();
    checkOutput("pattern", 32'(pattern), 32'(mPattern));
    checkOutput("pulse_width", 32'(pulse_width), 32'(mPulse));
    checkOutput("frame_error", 32'(frame_error), 32'(mErr));
    checkOutput("miso_idle", 32'(miso), 32'd0);
  endtask

  // Master sends nbits of word MSB-first; fewer than 16 bits means an aborted frame.
  task automatic applyStimulus(input logic [15:0] word, input int nbits, input bit collide);
    logic [15:0] expRead;
    int          strobeBefore, updateBefore;
    expRead      = expectedReadback();
    strobeBefore = strobeCount;
    updateBefore = updateCount;
    capWord      = 16'h0000;
    @(negedge clock);
    ss_n = 1'b0;
    for (int i = 0; i < nbits; i++) begin
      mosi = word[15-i];
      sclk = 1'b0;
      waitClocks(5);
      capWord[15-i] = miso;
      sclk = 1'b1;
      if (collide && i == 15) begin
        waitClocks(1);
        latch_data_n = 1'b0;
        waitClocks(4);
      end else begin
        waitClocks(5);
      end
    end
    sclk = 1'b0;
    waitClocks(5);
    ss_n = 1'b1;
    waitClocks(8);
    if (collide) begin
      latch_data_n = 1'b1;
      waitClocks(6);
      mPattern = mShadow;
    end
    if (nbits == 16) begin
      checkOutput("readback", 32'(capWord), 32'(expRead));
      modelDecode(word);
    end else begin
      mErr = 1'b1;
    end
    checkOutput("strobe_count", 32'(strobeCount - strobeBefore), (nbits == 16) ? 32'd1 : 32'd0);
    checkOutput("update_count", 32'(updateCount - updateBefore), collide ? 32'd1 : 32'd0);
    checkState();
  endtask

  task automatic pulseLatch();
    int updateBefore;
    updateBefore = updateCount;
    latch_data_n = 1'b0;
    waitClocks(6);
    latch_data_n = 1'b1;
    waitClocks(6);
    mPattern = mShadow;
    checkOutput("latch_pattern", 32'(pattern), 32'(mPattern));
    checkOutput("latch_update_count", 32'(updateCount - updateBefore), 32'd1);
  endtask

  initial begin
    logic [15:0] word;
    logic [3:0]  cmd;
    int          sel, nbits;

    reset = 1'b1; sclk = 1'b0; mosi = 1'b0; ss_n = 1'b1; latch_data_n = 1'b1;
    modelReset();
    waitClocks(4);
    reset = 1'b0;
    waitClocks(4);
    checkState();
    checkOutput("reset_update", 32'(pattern_update), 32'd0);
    checkOutput("reset_strobe", 32'(frame_strobe), 32'd0);

    // Reset asserted mid-frame at bit 7 drops the frame without an error.
    applyStimulus(16'h1155, 16, 1'b0);
    pulseLatch();
    ss_n = 1'b0;
    for (int i = 0; i < 7; i++) begin
      mosi = 1'b1; sclk = 1'b0; waitClocks(5);
      sclk = 1'b1; waitClocks(5);
    end
    reset = 1'b1;
    waitClocks(3);
    sclk = 1'b0; ss_n = 1'b1;
    reset = 1'b0;
    modelReset();
    waitClocks(6);
    checkState();
    applyStimulus(16'h2037, 16, 1'b0);

    // Write and latch.
    applyStimulus(16'h12A5, 16, 1'b0);
    pulseLatch();

    // Pulse width, zero coerced to one.
    applyStimulus(16'h2000, 16, 1'b0);
    applyStimulus(16'h2FFF, 16, 1'b0);

    // Abort after 9 bits, then clear.
    applyStimulus(16'h2123, 9, 1'b0);
    applyStimulus(16'h3000, 16, 1'b0);

    // Readback with pattern 0x155 and error set.
    applyStimulus(16'h1155, 16, 1'b0);
    pulseLatch();
    applyStimulus(16'h1000, 5, 1'b0);
    applyStimulus(16'hF000, 16, 1'b0);
`ifdef BRAILLE_SPI_READBACK_EN
    checkOutput("readback_A555", 32'(capWord), 32'h0000A555);
`else
    checkOutput("readback_tied", 32'(capWord), 32'h00000000);
`endif

    // Latch edge coincides with WRITE_PATTERN decode.
    applyStimulus(16'h1001, 16, 1'b0);
    pulseLatch();
    applyStimulus(16'h13FF, 16, 1'b1);
    checkOutput("collide_pattern", 32'(pattern), 32'h001);
    pulseLatch();
    checkOutput("collide_next_latch", 32'(pattern), 32'h3FF);

    for (int n = 0; n < 24; n++) begin
      sel = $urandom_range(0, 3);
      cmd = (sel == 3) ? ((($urandom_range(0, 1)) == 0) ? 4'h0 : 4'($urandom_range(4, 15)))
                       : 4'(sel + 1);
      word  = {cmd, 12'($urandom_range(0, 4095))};
      if ($urandom_range(0, 9) == 0) word[11:0] = 12'h000;
      nbits = ($urandom_range(0, 5) == 0) ? $urandom_range(1, 15) : 16;
      applyStimulus(word, nbits, 1'b0);
      if ($urandom_range(0, 2) == 0) pulseLatch();
    end

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", compareCount, failCount);
    $finish;
  end

endmodule
